// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: steps the transmit chain through seed load, preamble, payload and drain for one frame
module tx_frame_sequencer #(
  parameter int PREAMBLE_LEN  = 8,
  parameter int BITS_PER_SYM  = 4,
  parameter int MAX_LEN       = 1023,
  parameter int FLUSH_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] seed_in,
  input  logic [9:0] payload_len,
  input  logic       dp_valid,
  output logic [6:0] lfsr_seed,
  output logic       lfsr_load,
  output logic       preamble_sel,
  output logic       src_en,
  output logic       flush,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [8:0] sym_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, PREAMBLE, PAYLOAD, FLUSH, DONE} state_t;
  localparam int          SH       = $clog2(BITS_PER_SYM);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] TO_LAST  = 16'(FLUSH_TIMEOUT - 1);
  localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
  localparam logic [9:0]  SYM_MASK = 10'(BITS_PER_SYM - 1);
  state_t      state, state_d;
  logic [15:0] cnt;
  logic [9:0]  len_q;
  logic [8:0]  sym_d;
  logic [10:0] exp_syms;
  logic [6:0]  outs_d;
  logic        bad_len, accept, reject, reached, timed_out;
  assign bad_len   = payload_len == '0 || {1'b0, payload_len} > MAX_L || (payload_len & SYM_MASK) != '0;
  assign accept    = state == IDLE && start && !bad_len;
  assign reject    = state == IDLE && start && bad_len;
  assign sym_d     = accept ? '0 : (state != IDLE && dp_valid && sym_cnt != '1) ? sym_cnt + 9'd1 : sym_cnt;
  assign exp_syms  = 11'(PREAMBLE_LEN) + {1'b0, (len_q >> SH)};
  assign reached   = {2'b0, sym_d} >= exp_syms;
  assign timed_out = cnt == TO_LAST;
  // state register; cnt measures cycles spent in the current state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state_d != state) ? '0 : cnt + 16'd1;
    end
  end
  // next state; abort overrides every other transition
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = accept ? LOAD : IDLE;
      LOAD:     state_d = PREAMBLE;
      PREAMBLE: state_d = cnt == PRE_LAST ? PAYLOAD : PREAMBLE;
      PAYLOAD:  state_d = cnt == {6'b0, len_q} - 16'd1 ? FLUSH : PAYLOAD;
      FLUSH:    state_d = reached ? DONE : timed_out ? IDLE : FLUSH;
      default:  state_d = IDLE;
    endcase
    if (abort && state != IDLE) state_d = IDLE;
  end
  // outputs decoded from the upcoming state so they can be registered without a cycle of lag
  always_comb begin
    outs_d = {state_d == LOAD, state_d == PREAMBLE, state_d == PAYLOAD, state_d == FLUSH,
              state_d != IDLE, state_d == DONE, reject || (state == FLUSH && state_d == IDLE && !abort)};
  end
  // output registers, frame latches and symbol counter
  always_ff @(posedge clk) begin
    if (reset) begin
      {lfsr_load, preamble_sel, src_en, flush, busy, done, err} <= '0;
      lfsr_seed <= '0;
      len_q     <= '0;
      sym_cnt   <= '0;
    end else begin
      {lfsr_load, preamble_sel, src_en, flush, busy, done, err} <= outs_d;
      sym_cnt <= sym_d;
      if (accept) begin
        lfsr_seed <= seed_in;
        len_q     <= payload_len;
      end
    end
  end
endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: directed and random frames checked against a cycle-schedule reference model
module tb_tx_frame_sequencer;
  localparam int P = 8, BPS = 4, MAXL = 1000, FT = 64;
  logic       clk = 0, reset = 1, start = 0, abort = 0, dp_valid = 0;
  logic [6:0] seed_in = 0;
  logic [9:0] payload_len = 0;
  logic [6:0] lfsr_seed;
  logic       lfsr_load, preamble_sel, src_en, flush, busy, done, err;
  logic [8:0] sym_cnt;
  int         vectors = 0, miscompares = 0, last_cnt = 0;
  logic [6:0] cur_seed = 0;
  bit         emit [0:4095];

  tx_frame_sequencer #(.PREAMBLE_LEN(P), .BITS_PER_SYM(BPS), .MAX_LEN(MAXL), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .seed_in(seed_in),
    .payload_len(payload_len), .dp_valid(dp_valid), .lfsr_seed(lfsr_seed), .lfsr_load(lfsr_load),
    .preamble_sel(preamble_sel), .src_en(src_en), .flush(flush), .busy(busy), .done(done),
    .err(err), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic chk_outs(input string ph, input bit l, input bit p, input bit s, input bit f,
                          input bit b, input bit d, input bit e, input int sc, input logic [6:0] sd);
    chk({ph, " lfsr_load"}, lfsr_load, l);
    chk({ph, " preamble_sel"}, preamble_sel, p);
    chk({ph, " src_en"}, src_en, s);
    chk({ph, " flush"}, flush, f);
    chk({ph, " busy"}, busy, b);
    chk({ph, " done"}, done, d);
    chk({ph, " err"}, err, e);
    chk({ph, " sym_cnt"}, sym_cnt, sc);
    chk({ph, " lfsr_seed"}, lfsr_seed, sd);
  endtask

  // Model: cycle k counts from the start edge; the chain emits one symbol per preamble cycle and one
  // per BPS payload bits, delayed by dly cycles. outcome 0 running, 1 done, 2 timeout, 3 aborted/reset.
  task automatic frame(input logic [6:0] seed, input int len, input int dly, input int drop_pct,
                       input bit stuck, input int abort_k, input int restart_k, input int rst_k);
    int exp_syms, f0, cnt, outcome;
    bit e_pre, e_src, e_flush, dpv;
    logic [6:0] sd;
    exp_syms = P + len / BPS;
    f0 = 2 + P + len;
    cnt = 0;
    outcome = 0;
    sd = seed;
    seed_in = seed;
    payload_len = 10'(len);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int k = 1; k < 4096; k++) begin
      e_pre = outcome == 0 && k >= 2 && k <= 1 + P;
      e_src = outcome == 0 && k >= 2 + P && k < f0;
      e_flush = outcome == 0 && k >= f0;
      chk_outs("frame", outcome == 0 && k == 1, e_pre, e_src, e_flush, outcome <= 1,
               outcome == 1, outcome == 2, cnt, sd);
      if (outcome != 0) break;
      emit[k] = e_pre || (e_src && (k - 2 - P) % BPS == BPS - 1);
      dpv = stuck || (k > dly && emit[k - dly] && int'($urandom_range(99)) >= drop_pct);
      dp_valid = dpv;
      abort = k == abort_k;
      start = k == restart_k;
      reset = k == rst_k;
      if (k == restart_k) begin
        seed_in = ~seed;
        payload_len = 10'd6;
      end
      if (k == rst_k) begin
        outcome = 3;
        cnt = 0;
        sd = '0;
      end else begin
        if (dpv && cnt < 511) cnt++;
        if (k == abort_k) outcome = 3;
        else if (e_flush && cnt >= exp_syms) outcome = 1;
        else if (e_flush && k == f0 + FT - 1) outcome = 2;
      end
      @(posedge clk); #1;
    end
    {dp_valid, abort, start, reset} = '0;
    @(posedge clk); #1;
    chk_outs("settle", 0, 0, 0, 0, 0, 0, 0, cnt, sd);
    cur_seed = sd;
    last_cnt = cnt;
  endtask

  task automatic reject(input int len);
    seed_in = 7'($urandom);
    payload_len = 10'(len);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk_outs("reject", 0, 0, 0, 0, 0, 0, 1, last_cnt, cur_seed);
    @(posedge clk); #1;
    chk_outs("reject_after", 0, 0, 0, 0, 0, 0, 0, last_cnt, cur_seed);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    @(posedge clk); #1;
    chk_outs("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    frame(7'h55, 256, 5, 0, 0, -1, -1, -1);
    reject(6);
    reject(0);
    reject(1004);
    reject(1001);
    frame(7'h2a, 64, 3, 0, 0, -1, 2 + P + 20, -1);
    frame(7'h11, 400, 4, 0, 0, 2 + P + 99, -1, -1);
    frame(7'h3c, 128, 2, 0, 0, -1, -1, -1);
    frame(7'h0f, 16, 5, 100, 0, -1, -1, -1);
    frame(7'h44, 32, 3, 0, 0, -1, -1, 5);
    frame(7'h55, 256, 5, 0, 0, -1, -1, -1);
    frame(7'h01, 4, 1, 0, 0, -1, -1, -1);
    frame(7'h7f, 1000, 1, 0, 1, -1, -1, -1);
    reject(1008);
    for (int i = 0; i < 6; i++)
      frame(7'($urandom), 4 * int'($urandom_range(250, 1)), int'($urandom_range(8, 1)),
            i < 4 ? 0 : 15, 0, -1, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
